// File: rtl/morse_seq_buffer_if.sv
// Encoder-side and consumer-side signals of morse_seq_buffer.
// The master drives the symbol bus and the ready; the slave (the buffer) drives the queue head and status.
interface morse_seq_buffer_if #(
  parameter int MAX_SYMBOLS = 5,
  parameter int DEPTH       = 4
);
  localparam int SW = 2 * MAX_SYMBOLS;
  localparam int LW = $clog2(MAX_SYMBOLS + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    Signals;
  logic          SeqReady;
  logic          SeqValid;
  logic [SW-1:0] EncSeq;
  logic [LW-1:0] SeqLen;
  logic          Space_EndSeqbar;
  logic          SentFlag;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          TooLong;

  modport master (
    output Signals, SeqReady,
    input  SeqValid, EncSeq, SeqLen, Space_EndSeqbar, SentFlag, Full, Count, Overflow, TooLong
  );

  modport slave (
    input  Signals, SeqReady,
    output SeqValid, EncSeq, SeqLen, Space_EndSeqbar, SentFlag, Full, Count, Overflow, TooLong
  );
endinterface

// File: rtl/morse_seq_buffer.sv
// Morse sequence assembler with a FWFT queue of finished sequences.
// Symbols are edge-detected on the encoder bus (accepted only after an idle sample),
// packed two bits per slot, and closed into the queue on Space/EndSeq.
module morse_seq_buffer #(
  parameter int MAX_SYMBOLS = 5,
  parameter int DEPTH       = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  morse_seq_buffer_if.slave  bus
);
  localparam int SW = 2 * MAX_SYMBOLS;
  localparam int LW = $clog2(MAX_SYMBOLS + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [SW-1:0] seq;
    logic [LW-1:0] len;
    logic          term;   // 1 = Space, 0 = EndSeq
  } entry_t;

  entry_t                       mem [DEPTH];
  entry_t                       head;
  logic [2:0]                   prev;
  logic [MAX_SYMBOLS-1:0][1:0]  slots;
  logic [LW-1:0]                len;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         sent, overflow, too_long;
  logic                         accept, is_sym, is_term, pop, room, push_ok;

  // Acceptance qualifiers and queue handshake decisions.
  always_comb begin
    accept  = (prev == 3'b000) && (bus.Signals >= 3'd1) && (bus.Signals <= 3'd4);
    is_sym  = accept && (bus.Signals <= 3'd2);
    is_term = accept && (bus.Signals >= 3'd3);
    pop     = (count != '0) && bus.SeqReady;
    // A full queue still takes a push when the head leaves on the same edge.
    room    = (count != CW'(DEPTH)) || pop;
    push_ok = is_term && room;
  end

  // Sequence assembly: slot packing, length and the symbol-overrun flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev     <= '0;
      slots    <= '1;
      len      <= '0;
      too_long <= 1'b0;
    end else if (Clear) begin
      prev     <= '0;
      slots    <= '1;
      len      <= '0;
      too_long <= 1'b0;
    end else begin
      prev <= bus.Signals;
      if (is_term) begin
        // Assembly restarts even when the push is dropped.
        slots <= '1;
        len   <= '0;
      end else if (is_sym) begin
        if (len == LW'(MAX_SYMBOLS)) begin
          too_long <= 1'b1;
        end else begin
          for (int i = 0; i < MAX_SYMBOLS; i++)
            if (LW'(i) == len) slots[i] <= {1'b0, bus.Signals == 3'd2};
          len <= len + 1'b1;
        end
      end
    end
  end

  // Queue pointers, occupancy and the sent/overflow flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sent     <= 1'b0;
      overflow <= 1'b0;
    end else if (Clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sent     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sent <= push_ok && (bus.Signals == 3'd4);
      if (is_term && !room) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge Clk) begin
    if (push_ok && !Clear && Reset) begin
      mem[wr_ptr].seq  <= slots;
      mem[wr_ptr].len  <= len;
      mem[wr_ptr].term <= (bus.Signals == 3'd3);
    end
  end

  assign head                = mem[rd_ptr];
  assign bus.SeqValid        = (count != '0);
  assign bus.EncSeq          = bus.SeqValid ? head.seq  : '1;
  assign bus.SeqLen          = bus.SeqValid ? head.len  : '0;
  assign bus.Space_EndSeqbar = bus.SeqValid ? head.term : 1'b0;
  assign bus.SentFlag        = sent;
  assign bus.Full            = (count == CW'(DEPTH));
  assign bus.Count           = count;
  assign bus.Overflow        = overflow;
  assign bus.TooLong         = too_long;
endmodule

// File: tb/tb_morse_seq_buffer.sv
// Bench for morse_seq_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_morse_seq_buffer;
  localparam int MAX   = 5;
  localparam int DEPTH = 4;
  localparam int SW    = 2 * MAX;

  logic Clk = 1'b0;
  logic Reset, Clear;
  always #5 Clk = ~Clk;

  morse_seq_buffer_if #(.MAX_SYMBOLS(MAX), .DEPTH(DEPTH)) bus ();
  morse_seq_buffer #(.MAX_SYMBOLS(MAX), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .bus(bus)
  );

  typedef struct {
    logic [SW-1:0] seq;
    int            len;
    bit            term;
  } ent_t;

  ent_t fifo_q[$];
  int   sym_q[$];
  int   prev_sig;
  bit   m_sent, m_ovf, m_long;
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    fifo_q.delete();
    sym_q.delete();
    prev_sig = 0;
    m_sent = 0;
    m_ovf = 0;
    m_long = 0;
  endfunction

  // One clock edge of the reference behaviour, from the sampled inputs.
  function automatic void model_edge(input int s, input bit r, input bit c);
    bit   pop, acc;
    ent_t e;
    if (c) begin
      model_reset();
      return;
    end
    pop    = (fifo_q.size() > 0) && r;
    acc    = (prev_sig == 0) && (s >= 1) && (s <= 4);
    m_sent = 0;
    if (acc && s <= 2) begin
      if (sym_q.size() < MAX) sym_q.push_back(s == 2 ? 1 : 0);
      else m_long = 1;
    end
    if (pop) void'(fifo_q.pop_front());
    if (acc && s >= 3) begin
      e.seq = '1;
      foreach (sym_q[i]) e.seq[2*i +: 2] = 2'(sym_q[i]);
      e.len  = sym_q.size();
      e.term = (s == 3);
      if (fifo_q.size() < DEPTH) begin
        fifo_q.push_back(e);
        m_sent = (s == 4);
      end else begin
        m_ovf = 1;
      end
      sym_q.delete();
    end
    prev_sig = s;
  endfunction

  task automatic check_all();
    chk("valid", bus.SeqValid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("enc",  bus.EncSeq, fifo_q[0].seq);
      chk("len",  bus.SeqLen, fifo_q[0].len);
      chk("term", bus.Space_EndSeqbar, fifo_q[0].term);
    end else begin
      chk("enc_e",  bus.EncSeq, {SW{1'b1}});
      chk("len_e",  bus.SeqLen, 0);
      chk("term_e", bus.Space_EndSeqbar, 0);
    end
    chk("sent",  bus.SentFlag, m_sent);
    chk("full",  bus.Full, fifo_q.size() == DEPTH);
    chk("count", bus.Count, fifo_q.size());
    chk("ovf",   bus.Overflow, m_ovf);
    chk("long",  bus.TooLong, m_long);
  endtask

  task automatic tick(input logic [2:0] s, input logic r, input logic c);
    bus.Signals  = s;
    bus.SeqReady = r;
    Clear        = c;
    @(posedge Clk);
    model_edge(int'(s), r, c);
    #1;
    check_all();
  endtask

  task automatic sym(input logic [2:0] s);
    tick(s, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0;
    Clear = 1'b0;
    bus.Signals  = 3'd0;
    bus.SeqReady = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    Reset = 1'b1;

    // Dot Dash Dot Dot Space
    sym(3'd1); sym(3'd2); sym(3'd1); sym(3'd1); sym(3'd3);
    chk("t1_enc",   bus.EncSeq, 10'b11_00_00_01_00);
    chk("t1_len",   bus.SeqLen, 4);
    chk("t1_term",  bus.Space_EndSeqbar, 1);
    chk("t1_count", bus.Count, 1);

    // Word gap, then the same letter closed by EndSeq
    sym(3'd3);
    sym(3'd1); sym(3'd2); sym(3'd1); sym(3'd1);
    tick(3'd4, 1'b0, 1'b0);
    chk("t2_sent1", bus.SentFlag, 1);
    tick(3'd0, 1'b0, 1'b0);
    chk("t2_sent0", bus.SentFlag, 0);
    chk("t2_count", bus.Count, 3);
    tick(3'd0, 1'b1, 1'b0);
    chk("t2_e2len", bus.SeqLen, 0);
    chk("t2_e2enc", bus.EncSeq, 10'h3ff);
    tick(3'd0, 1'b1, 1'b0);
    chk("t2_e3enc",  bus.EncSeq, 10'b11_00_00_01_00);
    chk("t2_e3term", bus.Space_EndSeqbar, 0);
    tick(3'd0, 1'b1, 1'b0);
    chk("t2_empty", bus.SeqValid, 0);

    // Held Dot and an invalid code give one symbol
    repeat (5) tick(3'd1, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd7, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd4, 1'b0, 1'b0);
    chk("t3_len", bus.SeqLen, 1);
    tick(3'd0, 1'b1, 1'b0);

    // Six Dashes overrun the slots
    repeat (6) sym(3'd2);
    sym(3'd3);
    chk("t4_enc",  bus.EncSeq, 10'b01_01_01_01_01);
    chk("t4_len",  bus.SeqLen, 5);
    chk("t4_long", bus.TooLong, 1);
    tick(3'd0, 1'b1, 1'b0);

    // Fill past capacity, then push with a simultaneous pop, then Clear
    tick(3'd0, 1'b0, 1'b1);
    repeat (5) sym(3'd3);
    chk("t5_full",  bus.Full, 1);
    chk("t5_count", bus.Count, 4);
    chk("t5_ovf",   bus.Overflow, 1);
    tick(3'd3, 1'b1, 1'b0);
    chk("t5_count2", bus.Count, 4);
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b1);
    chk("t5_clr_cnt", bus.Count, 0);
    chk("t5_clr_ovf", bus.Overflow, 0);

    // Asynchronous reset mid-assembly with two entries queued
    sym(3'd3); sym(3'd3);
    sym(3'd1); sym(3'd1);
    Reset = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", bus.SeqValid, 0);
    chk("t6_count", bus.Count, 0);
    check_all();
    Reset = 1'b1;
    sym(3'd2); sym(3'd3);
    chk("t6_enc", bus.EncSeq, 10'b11_11_11_11_01);
    chk("t6_len", bus.SeqLen, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [2:0]  s;
      r = $urandom_range(0, 11);
      if (r <= 4)       s = 3'd0;
      else if (r <= 6)  s = 3'd1;
      else if (r <= 8)  s = 3'd2;
      else if (r == 9)  s = 3'd3;
      else if (r == 10) s = 3'd4;
      else              s = 3'($urandom_range(5, 7));
      tick(s, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_seq_buffer.md
Name: morse_seq_buffer

Overview:
Parametrised successor to sequence_producer. Assembles Dot/Dash symbols from the morse_code_encoder Signals bus into a slot-packed EncSeq word of up to MAX_SYMBOLS symbols. On Space or EndSeq it closes the sequence and queues it in a DEPTH-entry first-word-fall-through FIFO. A downstream decoder/display drains the FIFO with a valid/ready handshake, so symbols keep arriving while earlier sequences are still being consumed.

Parameters:
MAX_SYMBOLS, 5, maximum Dot/Dash symbols per sequence; EncSeq width is 2*MAX_SYMBOLS.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
Clk  in  1  rising-edge clock.
Reset  in  1  asynchronous, active-low reset.
Clear  in  1  synchronous clear, active-high.
Signals  in  3  encoder bus: 000 idle, 001 Dot, 010 Dash, 011 Space, 100 EndSeq; 101/110/111 invalid.
SeqReady  in  1  consumer accepts head entry.
SeqValid  out  1  FIFO non-empty; head entry presented.
EncSeq  out  2*MAX_SYMBOLS  head sequence. Slot i = bits [2i+1:2i], slot 0 = first symbol. Codes: Dot 00, Dash 01, unused 11.
SeqLen  out  $clog2(MAX_SYMBOLS+1)  symbols in head entry.
Space_EndSeqbar  out  1  head terminator: 1 = Space, 0 = EndSeq.
SentFlag  out  1  one-cycle pulse after an EndSeq-terminated entry is queued.
Full  out  1  FIFO holds DEPTH entries.
Count  out  $clog2(DEPTH+1)  FIFO occupancy.
Overflow  out  1  sticky: a terminated sequence was dropped because the FIFO was full.
TooLong  out  1  sticky: a symbol was dropped because the sequence already held MAX_SYMBOLS.

Behaviour:
- Reset low, asynchronous: FIFO empty, assembly slots all 11, assembly count 0, prev-sample register 000, all flags 0.
- Empty-FIFO outputs: SeqValid 0, EncSeq all ones, SeqLen 0, Space_EndSeqbar 0.
- Clear=1 at an edge: same state as reset. Clear has priority over Signals and SeqReady.
- Symbol acceptance: Signals is sampled each edge. A code is accepted only when the current sample is 001–100 and the previous sample was 000. Holding a code for several cycles yields exactly one symbol. Invalid codes are never accepted but still count as non-idle, so they block acceptance until the bus returns to 000.
- Dot/Dash accepted with count < MAX_SYMBOLS: code written to slot[count], count+1.
- Dot/Dash accepted with count = MAX_SYMBOLS: symbol discarded, TooLong set, assembly unchanged.
- Space/EndSeq accepted:
  - Push {slots, count, terminator} into the FIFO. Zero-length sequences are pushed (word gap).
  - Assembly resets to all 11, count 0, in the same edge.
- Push latency: the terminator sampled at edge k is visible at the head (if the FIFO was empty) from edge k onward, i.e. SeqValid=1 in cycle k+1.
- SentFlag: 1 for exactly the cycle after an EndSeq push succeeds; not asserted on dropped pushes.
- Pop: when SeqValid & SeqReady at an edge, the head advances.
- Outputs are registered FIFO contents with no combinational path from Signals. SeqReady may affect only the next-state logic.
- Full push, no pop: entry dropped, Overflow set, assembly still cleared.
- Full push with simultaneous pop: both proceed; Count is unchanged and Overflow is not set.
- Empty with SeqReady=1: no effect.
- Read/write pointers wrap modulo DEPTH. Count is 0..DEPTH.
- Overflow and TooLong clear only on reset or Clear.
- Reset asserted mid-sequence: partial assembly is lost and nothing is queued.

Test Plan:
- Dot, Dash, Dot, Dot, Space (each 1 cycle high, 1 idle), SeqReady=0 -> SeqValid=1, EncSeq=10'b11_00_00_01_00, SeqLen=4, Space_EndSeqbar=1, Count=1, SentFlag stays 0.
- Then Space alone, then Dot, Dash, Dot, Dot, EndSeq:
  - Entry 2: SeqLen=0, EncSeq=all ones, Space_EndSeqbar=1.
  - Entry 3 matches entry 1 with Space_EndSeqbar=0.
  - SentFlag pulses once, one cycle after the EndSeq edge.
  - Popping with SeqReady=1 returns entries in order, then SeqValid=0.
- Dot held high for 5 cycles, then idle, then EndSeq -> SeqLen=1, not 5. Invalid code 111 between symbols -> no extra symbol.
- Six Dashes then Space -> SeqLen=5, EncSeq=10'b01_01_01_01_01, TooLong=1.
- With DEPTH=4, SeqReady=0: push 5 sequences -> Full=1, Count=4, Overflow=1, 5th lost. Then push while SeqReady=1 on the same edge -> Count stays 4, Overflow unchanged. Clear -> Count=0, flags 0.
- Reset low mid-assembly after two Dots, with 2 FIFO entries queued -> immediately SeqValid=0, Count=0. After release, Dash, Space -> SeqLen=1, EncSeq=10'b11_11_11_11_01.
